// File: rtl/wb_select_stage.sv
// ============================================================================
// Module   : wb_select_stage
// Brief    : Registered MEM/WB writeback select stage with load extension,
//            misalign detection, x0 suppression and stall/flush control.
//            Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_select_stage #(
   parameter int XLEN       = 32,
   parameter int NUM_SRC    = 4,
   parameter int REG_ADDR_W = 5,
   localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic                          in_stall,
   input  logic                          in_flush,
   input  logic [XLEN-1:0]               mem_rdata,
   input  logic [1:0]                    mem_addr_lo,
   input  logic [2:0]                    load_f3,
   input  logic [(NUM_SRC-1)*XLEN-1:0]   alt_src,
   input  logic [SEL_W-1:0]              wb_sel,
   input  logic [REG_ADDR_W-1:0]         rd_in,
   input  logic                          reg_write,
`ifdef WB_RETIRE_CNT_EN
   output logic [63:0]                   retire_cnt,
`endif
   output logic                          wb_valid,
   output logic                          wb_we,
   output logic [REG_ADDR_W-1:0]         wb_rd,
   output logic [XLEN-1:0]               wb_data,
   output logic                          wb_misalign
);

   logic                  valid_q, valid_d;
   logic                  we_q, we_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic [XLEN-1:0]       data_q, data_d;
   logic                  misalign_q, misalign_d;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0]           retire_cnt_q, retire_cnt_d;
`endif

   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] load_data;
   logic            load_bad;
   logic [XLEN-1:0] alt_data;
   logic            sel_legal;
   logic            sel_load;
   logic            misalign;

   // Load alignment and extension; unsupported funct3 encodings count as illegal.
   always_comb begin
      ld_byte   = mem_rdata[{mem_addr_lo, 3'b000} +: 8];
      ld_half   = mem_rdata[{mem_addr_lo[1], 4'b0000} +: 16];
      load_data = '0;
      load_bad  = 1'b0;
      case (load_f3)
         3'b000: load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001: begin
            load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            load_bad  = mem_addr_lo[0];
         end
         3'b010: begin
            load_data = mem_rdata;
            load_bad  = (mem_addr_lo != 2'b00);
         end
         3'b100: load_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101: begin
            load_data = {{(XLEN-16){1'b0}}, ld_half};
            load_bad  = mem_addr_lo[0];
         end
         default: load_bad = 1'b1;
      endcase
   end

   always_comb begin
      alt_data = '0;
      for (int k = 1; k < NUM_SRC; k++) begin
         if (int'(wb_sel) == k) begin
            alt_data = alt_src[(k-1)*XLEN +: XLEN];
         end
      end
      sel_legal = (int'(wb_sel) < NUM_SRC);
      sel_load  = (wb_sel == '0);
      misalign  = in_valid & sel_load & load_bad;
   end

   always_comb begin
      valid_d    = valid_q;
      we_d       = we_q;
      rd_d       = rd_q;
      data_d     = data_q;
      misalign_d = misalign_q;
`ifdef WB_RETIRE_CNT_EN
      retire_cnt_d = retire_cnt_q;
`endif
      // Flush overrides stall so a killed instruction never lingers in the stage.
      if (in_flush) begin
         valid_d    = 1'b0;
         we_d       = 1'b0;
         rd_d       = '0;
         data_d     = '0;
         misalign_d = 1'b0;
      end else if (!in_stall) begin
         valid_d    = in_valid;
         we_d       = in_valid & reg_write & (rd_in != '0) & sel_legal & ~misalign;
         rd_d       = rd_in;
         misalign_d = misalign;
         if (!sel_legal || misalign) begin
            data_d = '0;
         end else if (sel_load) begin
            data_d = load_data;
         end else begin
            data_d = alt_data;
         end
`ifdef WB_RETIRE_CNT_EN
         if (in_valid) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         we_q       <= 1'b0;
         rd_q       <= '0;
         data_q     <= '0;
         misalign_q <= 1'b0;
`ifdef WB_RETIRE_CNT_EN
         retire_cnt_q <= 64'd0;
`endif
      end else begin
         valid_q    <= valid_d;
         we_q       <= we_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
         misalign_q <= misalign_d;
`ifdef WB_RETIRE_CNT_EN
         retire_cnt_q <= retire_cnt_d;
`endif
      end
   end

   assign wb_valid    = valid_q;
   assign wb_we       = we_q;
   assign wb_rd       = rd_q;
   assign wb_data     = data_q;
   assign wb_misalign = misalign_q;
`ifdef WB_RETIRE_CNT_EN
   assign retire_cnt  = retire_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_select_stage.sv
// ============================================================================
// Module   : tb_wb_select_stage
// Brief    : Directed vector bench for wb_select_stage (retire counter checked
//            when WB_RETIRE_CNT_EN is defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_select_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_stall, in_flush;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_addr_lo;
   logic [2:0]  load_f3;
   logic [95:0] alt_src;
   logic [1:0]  wb_sel;
   logic [4:0]  rd_in;
   logic        reg_write;
   logic        wb_valid, wb_we, wb_misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retire_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_select_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_stall    (in_stall),
      .in_flush    (in_flush),
      .mem_rdata   (mem_rdata),
      .mem_addr_lo (mem_addr_lo),
      .load_f3     (load_f3),
      .alt_src     (alt_src),
      .wb_sel      (wb_sel),
      .rd_in       (rd_in),
      .reg_write   (reg_write),
`ifdef WB_RETIRE_CNT_EN
      .retire_cnt  (retire_cnt),
`endif
      .wb_valid    (wb_valid),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_misalign (wb_misalign)
   );

   typedef struct {
      logic        valid, stall, flush;
      logic [31:0] rdata;
      logic [1:0]  addr;
      logic [2:0]  f3;
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic        rw;
      logic        e_valid, e_we;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic        e_mis;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   function automatic vec_t mk(logic v, logic fl, logic [31:0] d, logic [1:0] a,
                               logic [2:0] f, logic [1:0] s, logic [4:0] r, logic w,
                               logic ev, logic ewe, logic [4:0] erd,
                               logic [31:0] edata, logic emis);
      vec_t t;
      t.valid = v;   t.stall = 1'b0; t.flush = fl;
      t.rdata = d;   t.addr = a;     t.f3 = f;  t.sel = s;
      t.rd = r;      t.rw = w;
      t.e_valid = ev; t.e_we = ewe; t.e_rd = erd; t.e_data = edata; t.e_mis = emis;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic ewe,
                          input logic [4:0] erd, input logic [31:0] edata, input logic emis);
      chk({tag, ".valid"},    {63'd0, wb_valid},    {63'd0, ev});
      chk({tag, ".we"},       {63'd0, wb_we},       {63'd0, ewe});
      chk({tag, ".rd"},       {59'd0, wb_rd},       {59'd0, erd});
      chk({tag, ".data"},     {32'd0, wb_data},     {32'd0, edata});
      chk({tag, ".misalign"}, {63'd0, wb_misalign}, {63'd0, emis});
   endtask

   task automatic drive(input vec_t t);
      in_valid    = t.valid;
      in_stall    = t.stall;
      in_flush    = t.flush;
      mem_rdata   = t.rdata;
      mem_addr_lo = t.addr;
      load_f3     = t.f3;
      wb_sel      = t.sel;
      rd_in       = t.rd;
      reg_write   = t.rw;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      alt_src = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h1111_1111};

      vecs[0]  = mk(1,0,32'h1234_80FF,2'd1,3'b000,2'd0,5'd3,1, 1,1,5'd3,32'hFFFF_FF80,0);
      vecs[1]  = mk(1,0,32'h1234_80FF,2'd1,3'b100,2'd0,5'd3,1, 1,1,5'd3,32'h0000_0080,0);
      vecs[2]  = mk(1,0,32'h1234_80FF,2'd2,3'b101,2'd0,5'd3,1, 1,1,5'd3,32'h0000_1234,0);
      vecs[3]  = mk(1,0,32'h1234_80FF,2'd0,3'b001,2'd0,5'd4,1, 1,1,5'd4,32'hFFFF_80FF,0);
      vecs[4]  = mk(1,0,32'h1234_80FF,2'd2,3'b000,2'd0,5'd4,1, 1,1,5'd4,32'h0000_0034,0);
      vecs[5]  = mk(1,0,32'h1234_80FF,2'd0,3'b010,2'd0,5'd5,1, 1,1,5'd5,32'h1234_80FF,0);
      vecs[6]  = mk(1,0,32'h1234_80FF,2'd1,3'b010,2'd0,5'd5,1, 1,0,5'd5,32'h0000_0000,1);
      vecs[7]  = mk(1,0,32'h1234_80FF,2'd0,3'b011,2'd0,5'd6,1, 1,0,5'd6,32'h0000_0000,1);
      vecs[8]  = mk(1,0,32'h1234_80FF,2'd1,3'b001,2'd0,5'd6,1, 1,0,5'd6,32'h0000_0000,1);
      vecs[9]  = mk(1,0,32'h1234_80FF,2'd0,3'b010,2'd2,5'd7,1, 1,1,5'd7,32'hDEAD_BEEF,0);
      vecs[10] = mk(1,0,32'h1234_80FF,2'd0,3'b010,2'd2,5'd0,1, 1,0,5'd0,32'hDEAD_BEEF,0);
      vecs[11] = mk(1,0,32'h0,       2'd0,3'b010,2'd3,5'd9,0, 1,0,5'd9,32'hCAFE_F00D,0);
      vecs[12] = mk(0,0,32'h0,       2'd0,3'b010,2'd1,5'd5,1, 0,0,5'd5,32'h1111_1111,0);
      vecs[13] = mk(1,0,32'h0,       2'd1,3'b110,2'd1,5'd4,1, 1,1,5'd4,32'h1111_1111,0);
      vecs[14] = mk(1,1,32'h1234_80FF,2'd0,3'b010,2'd2,5'd8,1, 0,0,5'd0,32'h0000_0000,0);

      // Reset asserted with active inputs: outputs zero immediately and held.
      rst_n = 1'b1;
      drive(vecs[9]);
      step;
      #2 rst_n = 1'b0;
      #1 chk_all("reset_async", 0, 0, 5'd0, 32'h0, 0);
      step;
      step;
      chk_all("reset_held", 0, 0, 5'd0, 32'h0, 0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk_all("reset_released", 0, 0, 5'd0, 32'h0, 0);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk) drive(vecs[i]);
         step;
         chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_we,
                 vecs[i].e_rd, vecs[i].e_data, vecs[i].e_mis);
      end

      // Stall: capture a write, then freeze for three cycles with changing inputs.
      @(negedge clk) drive(vecs[9]);
      step;
      chk_all("pre_stall", 1, 1, 5'd7, 32'hDEAD_BEEF, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk) begin
            drive(vecs[c + 5]);
            in_stall = 1'b1;
         end
         step;
         chk_all($sformatf("stall%0d", c), 1, 1, 5'd7, 32'hDEAD_BEEF, 0);
      end
      @(negedge clk) in_flush = 1'b1;
      step;
      chk_all("stall_flush", 0, 0, 5'd0, 32'h0, 0);

      // Reset pulse while stalled: stage stays empty until first unstalled edge.
      @(negedge clk) begin
         drive(vecs[9]);
         in_stall = 1'b1;
      end
      step;
      chk_all("stall_after_flush", 0, 0, 5'd0, 32'h0, 0);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      step;
      chk_all("stall_after_reset", 0, 0, 5'd0, 32'h0, 0);
      @(negedge clk) in_stall = 1'b0;
      step;
      chk_all("unstall_capture", 1, 1, 5'd7, 32'hDEAD_BEEF, 0);

`ifdef WB_RETIRE_CNT_EN
      @(negedge clk) rst_n = 1'b0;
      #1 chk("retire_reset", retire_cnt, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk) begin
            drive(vecs[9]);
            in_flush = (c == 3 || c == 8);
            in_stall = (c == 5 || c == 6 || c == 11);
         end
         step;
      end
      chk("retire_count", retire_cnt, 64'd8);
`endif

      @(negedge clk) begin
         in_valid = 1'b0;
         in_stall = 1'b0;
         in_flush = 1'b0;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
